// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_pkg
// Description : Shared state encoding and timing defaults for key blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01
    } key_state_t;

    localparam int C_TIME_DC_DEFAULT = 15_000_000;
    localparam int C_CNT_W           = 24;

endpackage
`default_nettype wire

// File: rtl/key_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : key_prio_sel
// Description : Lowest-index request selector, one-hot grant plus valid.
// Revision    : 1.0 - initial release
// ============================================================================
module key_prio_sel #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] sel_onehot,
    output logic             sel_valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign sel_onehot = req & (~req + WIDTH'(1));
    assign sel_valid  = |req;

endmodule
`default_nettype wire

// File: rtl/key_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_click_decoder
// Description : Classifies key-release pulses into single and double clicks.
// Revision    : 1.0 - initial release
// ============================================================================
module key_click_decoder
    import key_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int TIME_DC = C_TIME_DC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_pulse,
    output logic [WIDTH-1:0] single_click,
    output logic [WIDTH-1:0] double_click,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIME_DC - 1);

    key_state_t         r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0]   r_pend_idx;
    logic [WIDTH-1:0]   r_single;
    logic [WIDTH-1:0]   r_double;
    logic               r_busy;

    logic [WIDTH-1:0]   w_sel_onehot;
    logic               w_sel_valid;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [WIDTH-1:0]   w_pend_onehot;
    logic               w_same_key;

    key_prio_sel #(
        .WIDTH (WIDTH)
    ) u_prio_sel (
        .req        (key_pulse),
        .sel_onehot (w_sel_onehot),
        .sel_valid  (w_sel_valid)
    );

    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    assign w_pend_onehot = WIDTH'(1) << r_pend_idx;
    assign w_same_key    = w_sel_valid && (w_sel_idx == r_pend_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_pend_idx <= '0;
            r_single   <= '0;
            r_double   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_single <= '0;
            r_double <= '0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_sel_valid) begin
                        r_pend_idx <= w_sel_idx;
                        r_state    <= WAIT;
                        r_busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    // A repeat press beats expiry in the same cycle.
                    if (w_same_key) begin
                        r_double <= w_pend_onehot;
                        r_cnt    <= '0;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end else if (w_sel_valid) begin
                        r_single   <= w_pend_onehot;
                        r_pend_idx <= w_sel_idx;
                        r_cnt      <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_single <= w_pend_onehot;
                        r_cnt    <= '0;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_key_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_click_decoder
// Description : Self-checking bench for key_click_decoder (WIDTH=4, TIME_DC=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_click_decoder;

    localparam int W   = 4;
    localparam int TDC = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] key_pulse = '0;
    logic [W-1:0] single_click;
    logic [W-1:0] double_click;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference model: pending key (-1 = none), edge index it was accepted at.
    int           now  = 0;
    int           pend = -1;
    int           t0   = 0;
    logic [W-1:0] exp_s = '0;
    logic [W-1:0] exp_d = '0;
    logic         exp_busy = 1'b0;

    key_click_decoder #(
        .WIDTH   (W),
        .TIME_DC (TDC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pulse    (key_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predicts outputs seen after the edge that samples pulse p (edge index now).
    task automatic model_step(input logic [W-1:0] p);
        int sel;
        sel   = -1;
        exp_s = '0;
        exp_d = '0;
        for (int i = 0; i < W; i++) begin
            if (p[i] && sel < 0) sel = i;
        end
        if (pend < 0) begin
            if (sel >= 0) begin
                pend = sel;
                t0   = now;
            end
        end else if (sel == pend) begin
            exp_d[pend] = 1'b1;
            pend = -1;
        end else if (sel >= 0) begin
            exp_s[pend] = 1'b1;
            pend = sel;
            t0   = now;
        end else if (now - t0 == TDC) begin
            exp_s[pend] = 1'b1;
            pend = -1;
        end
        exp_busy = (pend >= 0);
    endtask

    task automatic cycle(input logic [W-1:0] p);
        key_pulse = p;
        model_step(p);
        @(posedge clk);
        now++;
        @(negedge clk);
        check("single", 32'(single_click), 32'(exp_s));
        check("double", 32'(double_click), 32'(exp_d));
        check("busy",   32'(busy),         32'(exp_busy));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst       = 1'b1;
        key_pulse = '0;
        pend      = -1;
        exp_s     = '0;
        exp_d     = '0;
        exp_busy  = 1'b0;
        #1;
        check("rst_single", 32'(single_click), 32'h0);
        check("rst_double", 32'(double_click), 32'h0);
        check("rst_busy",   32'(busy),         32'h0);
        repeat (n) begin
            @(posedge clk);
            now++;
            @(negedge clk);
            check("rst_hold_busy", 32'(busy), 32'h0);
            check("rst_hold_clk",  32'(single_click | double_click), 32'h0);
        end
        rst = 1'b0;
    endtask

    initial begin
        #1;
        check("por_single", 32'(single_click), 32'h0);
        check("por_double", 32'(double_click), 32'h0);
        check("por_busy",   32'(busy),         32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Lone press on key 2 times out to a single click.
        cycle(4'b0100);
        repeat (9) begin
            cycle(4'b0000);
            check("s1_busy", 32'(busy), 32'h1);
        end
        cycle(4'b0000);
        check("s1_single", 32'(single_click), 32'h4);
        check("s1_busy_end", 32'(busy), 32'h0);
        repeat (3) cycle(4'b0000);

        // Key 1 twice, 5 cycles apart.
        cycle(4'b0010);
        repeat (4) cycle(4'b0000);
        cycle(4'b0010);
        check("s2_double", 32'(double_click), 32'h2);
        check("s2_no_single", 32'(single_click), 32'h0);
        repeat (3) cycle(4'b0000);

        // Key 0 then key 3: two singles.
        cycle(4'b0001);
        repeat (3) cycle(4'b0000);
        cycle(4'b1000);
        check("s3_single0", 32'(single_click), 32'h1);
        repeat (9) cycle(4'b0000);
        cycle(4'b0000);
        check("s3_single3", 32'(single_click), 32'h8);
        repeat (3) cycle(4'b0000);

        // Multi-bit press picks key 1; repeat lands on the expiry cycle.
        cycle(4'b0110);
        repeat (9) cycle(4'b0000);
        cycle(4'b0010);
        check("s4_double_tie", 32'(double_click), 32'h2);
        check("s4_no_single", 32'(single_click), 32'h0);
        repeat (3) cycle(4'b0000);

        // Reset mid-window discards the pending key.
        cycle(4'b0100);
        repeat (5) cycle(4'b0000);
        do_reset(2);
        repeat (15) begin
            cycle(4'b0000);
            check("s5_silent", 32'(single_click | double_click), 32'h0);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [W-1:0] p;
            r = int'($urandom_range(0, 9));
            p = '0;
            if (r < 2) begin
                p = W'($urandom);
            end else if (r == 2 && pend >= 0) begin
                p[pend] = 1'b1;
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            cycle(p);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
